// File: rtl/tdm_demux_16_pkg.sv
// tdm_pkg: shared sizes and types for the 16-slot TDM demultiplexer
package tdm_pkg;
   localparam int LANES = 16;
   localparam int SEL_W = $clog2(LANES);
   typedef enum logic {HUNT, RUN} state_t;
   typedef logic [SEL_W-1:0] slot_t;
endpackage

// File: rtl/tdm_demux_16_if.sv
// tdm_demux_16_if: serial-in / parallel-out bundle of the TDM demultiplexer
// lane_y exists only when TDM_DEMUX_LANE_OUT_EN is defined
interface tdm_demux_16_if;
   import tdm_pkg::*;
   logic             din;
   logic             din_valid;
   logic             frame_sync;
   logic [LANES-1:0] dout;
   logic             dout_valid;
   slot_t            slot;
   logic             sync_err;
`ifdef TDM_DEMUX_LANE_OUT_EN
   logic [LANES-1:0] lane_y;
   modport master (output din, din_valid, frame_sync, input dout, dout_valid, slot, sync_err, lane_y);
   modport slave (input din, din_valid, frame_sync, output dout, dout_valid, slot, sync_err, lane_y);
`else
   modport master (output din, din_valid, frame_sync, input dout, dout_valid, slot, sync_err);
   modport slave (input din, din_valid, frame_sync, output dout, dout_valid, slot, sync_err);
`endif
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: mod-LANES slot index with clear, load-to-1 and increment
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic  clk,
   input  logic  clr,
   input  logic  load,
   input  logic  inc,
   output slot_t slot,
   output logic  tc
);
   always_ff @(posedge clk) begin
      if (clr) slot <= '0;
      else if (load) slot <= slot_t'(1);
      else if (inc) slot <= slot + 1'b1;
   end
   assign tc = slot == slot_t'(LANES - 1);
endmodule

// File: rtl/tdm_demux_16.sv
// tdm_demux_16: rebuilds 16-bit words from a framed serial TDM stream
// TDM_DEMUX_LANE_OUT_EN adds the registered one-hot lane_y routing output
module tdm_demux_16
   import tdm_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   tdm_demux_16_if.slave  bus
);
   state_t           state, state_nx;
   slot_t            slot, wi;
   logic             tc, restart, capture, err, complete;
   logic [LANES-1:0] shadow, dout;
   logic             dout_valid, sync_err;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= HUNT;
      else state <= state_nx;
   end
   // any qualified sync restarts the frame at slot 0, in HUNT or RUN
   always_comb begin
      restart  = bus.din_valid && bus.frame_sync;
      capture  = bus.din_valid && (state == RUN || bus.frame_sync);
      err      = restart && state == RUN && slot != '0;
      complete = capture && !restart && tc;
      wi       = restart ? '0 : slot;
      state_nx = restart ? RUN : state;
   end
   tdm_slot_counter u_cnt (
      .clk  (clk),
      .clr  (!rst_n),
      .load (restart),
      .inc  (capture && !restart),
      .slot (slot),
      .tc   (tc)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow     <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         if (capture) shadow[wi] <= bus.din;
         if (complete) dout <= {bus.din, shadow[LANES-2:0]};
         dout_valid <= complete;
         sync_err   <= err;
      end
   end
   assign bus.dout       = dout;
   assign bus.dout_valid = dout_valid;
   assign bus.sync_err   = sync_err;
   assign bus.slot       = slot;
`ifdef TDM_DEMUX_LANE_OUT_EN
   logic [LANES-1:0] lane_y;
   always_ff @(posedge clk) begin
      if (!rst_n) lane_y <= '0;
      else lane_y <= capture ? {{(LANES-1){1'b0}}, bus.din} << wi : '0;
   end
   assign bus.lane_y = lane_y;
`endif
endmodule

// File: doc/tdm_demux_16.md
# tdm_demux_16

Sequential 1-to-16 time-division demultiplexer. Takes the single-bit output of a 16:1 mux driven by a free-running 4-bit select, and rebuilds the 16-bit source word. A frame-sync marker aligns slot 0. One serial bit is accepted per valid cycle and each complete frame is presented as a registered parallel word with a one-cycle strobe. Sits at the receive end of the TDM link, downstream of the mux_16x1 path.

## Interface
Parameters:
- LANES, 16, number of TDM slots per frame (fixed at 16 in this revision).
- SEL_W, 4, slot index width, $clog2(LANES).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low. Sampled on the rising edge of clk.
- din  input  1  serial data bit. Corresponds to the mux output y.
- din_valid  input  1  din is meaningful this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current din as slot 0.
- dout  output  LANES  last complete frame; bit k = slot k.
- dout_valid  output  1  one-cycle strobe, dout updated this cycle.
- slot  output  SEL_W  slot index the next valid bit will be written to.
- sync_err  output  1  one-cycle strobe, frame_sync arrived mid-frame.

## Operation
- States are HUNT and RUN.
- In HUNT, data bits are ignored until frame_sync and din_valid are both 1.
- HUNT, with din_valid and frame_sync both 1:
  - shadow[0] <= din.
  - slot <= 1.
  - go to RUN.
- RUN, with din_valid=1 and no conflicting sync:
  - shadow[slot] <= din.
  - slot <= slot+1, wrapping modulo 16.
- RUN, valid bit captured at slot==15:
  - dout <= {din, shadow[14:0]}.
  - dout_valid=1 on the next cycle.
  - slot <= 0.
  - stay in RUN.
- RUN, frame_sync=1 with slot==0: normal frame start, no error.
- RUN, frame_sync=1 with slot!=0:
  - sync_err=1 on the next cycle.
  - The partial frame is discarded; dout is unchanged and no dout_valid.
  - The current bit is written as slot 0, and slot <= 1.
- din_valid=0: no state change. frame_sync is ignored.
- Gaps between valid bits are allowed. A frame completes on its 16th valid bit, not on a cycle count.
- The shadow register is not cleared between frames. Every bit of dout always comes from the frame that just completed.

## Timing
- Reset values: dout=0, dout_valid=0, slot=0, sync_err=0, state=HUNT, shadow=0.
- Latency: dout and dout_valid are registered and appear 1 cycle after the edge that samples the 16th valid bit.
- Back-to-back frames need no gap: slot 0 of the next frame can be sampled on the cycle dout_valid is high.
- dout holds its value until the next complete frame.
- sync_err and dout_valid are never both 1.
- Reset applied mid-frame:
  - On the next edge, all outputs and state return to their reset values.
  - The partial frame is lost.
  - A bit presented in the reset cycle is dropped.
- slot output during HUNT: 0.

## Configuration
- Macro: TDM_DEMUX_LANE_OUT_EN.
- With the macro defined:
  - Adds output lane_y [LANES-1:0], a registered one-hot routing of din (the direct inverse of the mux).
  - On each cycle where a bit is captured into slot k, lane_y[k] <= din on that edge and every other bit is 0.
  - In all other cycles lane_y = 0.
  - Reset value is 0.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package tdm_pkg holds:
  - the LANES and SEL_W localparams;
  - the typedef for the state enum {HUNT, RUN};
  - the typedef for slot_t, logic [SEL_W-1:0].
- One sub-module, tdm_slot_counter:
  - holds the mod-16 slot counter;
  - inputs: increment, load-to-1, and clear;
  - outputs: slot and a terminal-count flag (slot==15).
- The shadow register, dout register, state machine and error logic live in the top module.

## Test plan
- Reset then one aligned frame:
  - Stimulus: frame_sync with the first bit, then 16 consecutive valid bits encoding 16'hA5C3, LSB first.
  - Required: dout=16'hA5C3 with one dout_valid pulse 1 cycle after the last bit; sync_err stays 0.
- Bubbles:
  - Stimulus: frame 16'h1234 with din_valid=0 inserted after every 3rd bit.
  - Required: dout=16'h1234 and exactly one dout_valid.
- Back-to-back frames:
  - Stimulus: frames 16'hFFFF then 16'h0001, with no gap between them.
  - Required: two dout_valid pulses exactly 16 cycles apart, with dout values FFFF then 0001.
- Mid-frame sync:
  - Stimulus: after 7 valid bits, frame_sync arrives; then a full frame 16'hBEEF follows, starting with that bit.
  - Required: sync_err pulses once; no dout_valid for the partial frame; dout=16'hBEEF after the 16th bit of the new frame.
- HUNT filtering:
  - Stimulus: 20 valid bits with no frame_sync, then a synced frame 16'h00FF.
  - Required: no strobes during the 20 unsynced bits; slot=0 throughout them; dout=16'h00FF after the synced frame.
- Mid-frame reset:
  - Stimulus: rst_n=0 for 1 cycle at slot 9, then a full frame 16'h8001.
  - Required: outputs are at reset values after the reset edge; dout=16'h8001 after the frame.
  - With TDM_DEMUX_LANE_OUT_EN defined, lane_y additionally shows a single-bit pattern: bit 0 is 1 on the slot 0 capture, bit 15 is 1 on the slot 15 capture, and lane_y is all 0 otherwise.
